// File: rtl/result_acc_if.sv
// result_acc_if: valid/ready bundle around result_acc.
// slave = the block (sample sink, window source); master = its surroundings.
interface result_acc_if #(
  parameter int WIDTH = 16,
  parameter int SUM_W = WIDTH + 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
`ifdef RESULT_ACC_MAX_EN
  logic [WIDTH-1:0] out_max;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_max
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_max
  );
`else
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum
  );
`endif
endinterface

// File: rtl/result_acc.sv
// result_acc: sums WINDOW unsigned samples, then holds the window result
// until taken. Ports: clk, rst (async high), bus (slave: in_* / out_*).
// Option RESULT_ACC_MAX_EN adds the window maximum on bus.out_max.
module result_acc #(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 4,
  parameter int SUM_W  = WIDTH + 8
) (
  input logic         clk,
  input logic         rst,
  result_acc_if.slave bus
);

  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic rdy;
  logic vld;
  logic take;
  logic last;

  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [SUM_W-1:0] acc_q;
  logic [SUM_W-1:0] acc_d;
  logic [SUM_W-1:0] acc_nx;
  logic [SUM_W-1:0] sum_q;
  logic [SUM_W-1:0] sum_d;

  // Data is only looked at behind take, so X on an idle bus
  // never lands in the accumulator.
  assign take   = bus.in_valid & rdy;
  assign last   = (cnt_q == LAST);
  assign acc_nx = acc_q + SUM_W'(bus.in_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdy     = 1'b0;
    vld     = 1'b0;
    unique case (state_q)
      ACCUM: begin
        rdy = 1'b1;
        if (bus.in_valid && last) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        vld = 1'b1;
        if (bus.out_ready) begin
          state_d = ACCUM;
        end
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    sum_d = sum_q;
    if (take) begin
      if (last) begin
        cnt_d = '0;
        acc_d = '0;
        sum_d = acc_nx;
      end else begin
        cnt_d = cnt_q + 1'b1;
        acc_d = acc_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.out_sum   = sum_q;

`ifdef RESULT_ACC_MAX_EN
  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] max_d;
  logic [WIDTH-1:0] max_nx;
  logic [WIDTH-1:0] omax_q;
  logic [WIDTH-1:0] omax_d;

  // Running max includes the sample arriving this cycle, so the
  // closing sample can still be the window maximum.
  assign max_nx = (bus.in_data > max_q) ? bus.in_data : max_q;

  always_comb begin
    max_d  = max_q;
    omax_d = omax_q;
    if (take) begin
      if (last) begin
        max_d  = '0;
        omax_d = max_nx;
      end else begin
        max_d  = max_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q  <= '0;
      omax_q <= '0;
    end else begin
      max_q  <= max_d;
      omax_q <= omax_d;
    end
  end

  assign bus.out_max = omax_q;
`endif

  a_hold_stable: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == HOLD && !bus.out_ready) |=> $stable(sum_q)
  );

  a_one_cycle: assert property (
    @(posedge clk) disable iff (rst)
    (take && last) |=> vld
  );

endmodule
